// File: rtl/ahb_sram_width_bridge.sv
// AHB-Lite width bridge: 32-bit upstream slave port to 16-bit downstream master port.
// Byte and halfword transfers pass straight through in one beat. A word transfer is
// split into two halfword beats (low half, then high half), which costs the upstream
// master one stall cycle per word when the downstream side has no wait states.
module ahb_sram_width_bridge #(
  parameter int unsigned W_ADDR = 32
) (
  input  logic              clk,
  input  logic              rst,

  // Upstream (32-bit) slave port
  output logic              ahbls_hready_resp,
  input  logic              ahbls_hready,
  output logic              ahbls_hresp,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [3:0]        ahbls_hprot,
  input  logic [31:0]       ahbls_hwdata,
  output logic [31:0]       ahbls_hrdata,

  // Downstream (16-bit) master port
  input  logic              ahblm_hready_resp,
  output logic              ahblm_hready,
  input  logic              ahblm_hresp,
  output logic [W_ADDR-1:0] ahblm_haddr,
  output logic              ahblm_hwrite,
  output logic [1:0]        ahblm_htrans,
  output logic [2:0]        ahblm_hsize,
  output logic [3:0]        ahblm_hprot,
  output logic [15:0]       ahblm_hwdata,
  input  logic [15:0]       ahblm_hrdata
);

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  // StSecond: the high-half beat is being issued downstream while the low half is in
  // its data phase.
  typedef enum logic [0:0] {
    StIdle,
    StSecond
  } state_e;

  // Kind of data phase currently pending on the downstream side.
  typedef enum logic [1:0] {
    DpNone,
    DpNarrow,
    DpWordLo,
    DpWordHi
  } dphase_e;

  state_e            state_q;
  dphase_e           dphase_q;
  logic              dp_addr1_q;   // haddr[1] of a narrow transfer, selects the write lane
  logic [15:0]       rdata_lo_q;   // low half of a word read
  logic [W_ADDR-1:0] sec_addr_q;   // address of the high-half beat (bit1 already set)
  logic              sec_write_q;
  logic [3:0]        sec_prot_q;

  logic              us_word;
  logic              us_accept;
  logic [W_ADDR-1:0] us_addr_lo;
  logic [W_ADDR-1:0] us_addr_hi;

  assign us_word    = (ahbls_hsize == 3'd2);
  assign us_accept  = ahbls_htrans[1] & ahbls_hready & ahblm_hready_resp;
  assign us_addr_lo = {ahbls_haddr[W_ADDR-1:2], 1'b0, ahbls_haddr[0]};
  assign us_addr_hi = {ahbls_haddr[W_ADDR-1:2], 1'b1, ahbls_haddr[0]};

  // Split FSM plus data-phase bookkeeping; reset discards any half-finished split.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      dphase_q    <= DpNone;
      dp_addr1_q  <= 1'b0;
      rdata_lo_q  <= 16'h0000;
      sec_addr_q  <= '0;
      sec_write_q <= 1'b0;
      sec_prot_q  <= 4'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Address phase passes through; it is accepted when downstream is ready.
          if (ahblm_hready_resp) begin
            if (us_accept) begin
              dp_addr1_q <= ahbls_haddr[1];
              if (us_word) begin
                dphase_q    <= DpWordLo;
                state_q     <= StSecond;
                sec_addr_q  <= us_addr_hi;
                sec_write_q <= ahbls_hwrite;
                sec_prot_q  <= ahbls_hprot;
              end else begin
                dphase_q <= DpNarrow;
              end
            end else begin
              dphase_q <= DpNone;
            end
          end
        end
        StSecond: begin
          if (ahblm_hready_resp) begin
            // Low half done and high-half address accepted in the same edge.
            state_q    <= StIdle;
            dphase_q   <= DpWordHi;
            rdata_lo_q <= ahblm_hrdata;
          end else if (ahblm_hresp) begin
            // First cycle of an error on the low half: drop the high half. The data
            // phase stays DpWordLo so the error's second cycle reaches the master.
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Response path back to the upstream master.
  always_comb begin
    ahblm_hready = ahblm_hready_resp;
    ahbls_hresp  = ahblm_hresp;
    // The low half of a word never completes the upstream transfer, except for the
    // second cycle of an error response, which must be passed on unchanged.
    if (dphase_q == DpWordLo && !ahblm_hresp) begin
      ahbls_hready_resp = 1'b0;
    end else begin
      ahbls_hready_resp = ahblm_hready_resp;
    end
    if (dphase_q == DpWordHi) begin
      ahbls_hrdata = {ahblm_hrdata, rdata_lo_q};
    end else begin
      ahbls_hrdata = {ahblm_hrdata, ahblm_hrdata};
    end
  end

  // Downstream address phase: pass-through when idle, bridge-generated in StSecond.
  always_comb begin
    if (state_q == StSecond) begin
      ahblm_htrans = ahblm_hresp ? HtransIdle : HtransNonseq;
      ahblm_haddr  = sec_addr_q;
      ahblm_hsize  = 3'd1;
      ahblm_hwrite = sec_write_q;
      ahblm_hprot  = sec_prot_q;
    end else begin
      ahblm_htrans = ahbls_htrans & {2{ahbls_hready}};
      ahblm_haddr  = us_word ? us_addr_lo : ahbls_haddr;
      ahblm_hsize  = us_word ? 3'd1 : ahbls_hsize;
      ahblm_hwrite = ahbls_hwrite;
      ahblm_hprot  = ahbls_hprot;
    end
  end

  // Downstream write data lane select.
  always_comb begin
    unique case (dphase_q)
      DpWordLo: ahblm_hwdata = ahbls_hwdata[15:0];
      DpWordHi: ahblm_hwdata = ahbls_hwdata[31:16];
      DpNarrow: ahblm_hwdata = dp_addr1_q ? ahbls_hwdata[31:16] : ahbls_hwdata[15:0];
      default:  ahblm_hwdata = ahbls_hwdata[15:0];
    endcase
  end

endmodule

// File: tb/tb_ahb_sram_width_bridge.sv
// Directed bench for ahb_sram_width_bridge: a pipelined upstream master, a 16-bit
// downstream slave model with wait-state and error injection, and a beat scoreboard.
module tb_ahb_sram_width_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        ahbls_hready_resp;
  logic        ahbls_hready;
  logic        ahbls_hresp;
  logic [31:0] ahbls_haddr = '0;
  logic        ahbls_hwrite = 1'b0;
  logic [1:0]  ahbls_htrans = 2'b00;
  logic [2:0]  ahbls_hsize = 3'd0;
  logic [3:0]  ahbls_hprot = 4'h0;
  logic [31:0] ahbls_hwdata = '0;
  logic [31:0] ahbls_hrdata;

  logic        ahblm_hready_resp;
  logic        ahblm_hready;
  logic        ahblm_hresp;
  logic [31:0] ahblm_haddr;
  logic        ahblm_hwrite;
  logic [1:0]  ahblm_htrans;
  logic [2:0]  ahblm_hsize;
  logic [3:0]  ahblm_hprot;
  logic [15:0] ahblm_hwdata;
  logic [15:0] ahblm_hrdata;

  always #5 clk = ~clk;

  assign ahbls_hready = ahbls_hready_resp;

  ahb_sram_width_bridge #(.W_ADDR(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .ahbls_hready_resp (ahbls_hready_resp),
    .ahbls_hready      (ahbls_hready),
    .ahbls_hresp       (ahbls_hresp),
    .ahbls_haddr       (ahbls_haddr),
    .ahbls_hwrite      (ahbls_hwrite),
    .ahbls_htrans      (ahbls_htrans),
    .ahbls_hsize       (ahbls_hsize),
    .ahbls_hprot       (ahbls_hprot),
    .ahbls_hwdata      (ahbls_hwdata),
    .ahbls_hrdata      (ahbls_hrdata),
    .ahblm_hready_resp (ahblm_hready_resp),
    .ahblm_hready      (ahblm_hready),
    .ahblm_hresp       (ahblm_hresp),
    .ahblm_haddr       (ahblm_haddr),
    .ahblm_hwrite      (ahblm_hwrite),
    .ahblm_htrans      (ahblm_htrans),
    .ahblm_hsize       (ahblm_hsize),
    .ahblm_hprot       (ahblm_hprot),
    .ahblm_hwdata      (ahblm_hwdata),
    .ahblm_hrdata      (ahblm_hrdata)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [15:0] wdata;
  } beat_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } xfer_t;

  // ---------------- downstream slave model ----------------
  int          cfg_wait = 0;
  logic [31:0] cfg_err_addr = 32'hFFFF_FFFF;

  logic        s_v = 1'b0;
  logic        s_err = 1'b0;
  logic        s_err2 = 1'b0;
  int          s_cnt = 0;
  logic [31:0] s_addr = '0;
  logic        s_write = 1'b0;
  logic [2:0]  s_size = '0;
  logic [3:0]  s_prot = '0;
  int          cyc = 0;
  beat_t       obs_q[$];
  int          cycq[$];

  function automatic logic [15:0] rd_fn(input logic [31:0] a);
    logic [31:0] h;
    h = {a[31:1], 1'b0};
    if (h == 32'h200) return 16'hBEEF;
    if (h == 32'h202) return 16'hCAFE;
    return {~h[7:0], h[7:0]};
  endfunction

  assign ahblm_hready_resp = !s_v || (s_err ? s_err2 : (s_cnt == 0));
  assign ahblm_hresp       = s_v && s_err;
  assign ahblm_hrdata      = rd_fn(s_addr);

  // Slave: record each completed beat, then take the next address phase.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      s_v    <= 1'b0;
      s_err  <= 1'b0;
      s_err2 <= 1'b0;
      s_cnt  <= 0;
    end else begin
      if (ahblm_hready_resp) begin
        if (s_v) begin
          obs_q.push_back({s_addr, s_write, s_size, s_prot, s_write ? ahblm_hwdata : 16'h0});
          cycq.push_back(cyc);
        end
        s_v <= 1'b0;
      end else if (s_err) begin
        s_err2 <= 1'b1;
      end else if (s_cnt != 0) begin
        s_cnt <= s_cnt - 1;
      end
      if (ahblm_hready && ahblm_htrans[1]) begin
        s_v     <= 1'b1;
        s_addr  <= ahblm_haddr;
        s_write <= ahblm_hwrite;
        s_size  <= ahblm_hsize;
        s_prot  <= ahblm_hprot;
        s_cnt   <= cfg_wait;
        s_err   <= (ahblm_haddr == cfg_err_addr);
        s_err2  <= 1'b0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int    total = 0;
  int    bad = 0;
  int    obs_rd = 0;
  beat_t exp_q[$];
  xfer_t xq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] a, input logic w, input logic [2:0] sz,
                               input logic [15:0] wd);
    return {a, w, sz, a[5:2], wd};
  endfunction

  task automatic add(input logic [31:0] a, input logic w, input logic [2:0] sz,
                     input logic [31:0] wd, input logic [31:0] rd);
    xq.push_back({a, w, sz, wd, rd});
  endtask

  task automatic chk_beats(input string tag);
    beat_t e;
    chk({tag, "_nbeats"}, 64'(obs_q.size() - obs_rd), 64'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin
        chk({tag, "_beat"}, 64'(obs_q[obs_rd]), 64'(e));
        obs_rd++;
      end
    end
  endtask

  // Pipelined upstream master: runs every queued transfer, counts data-phase cycles
  // and error-response cycles, checks read data of successful reads.
  task automatic run(input string tag, output int dcyc, output int errc);
    int a_i = 0;
    int d_i = 0;
    bit d_v = 1'b0;
    int guard = 0;
    int n = xq.size();
    dcyc = 0;
    errc = 0;
    while ((a_i < n || d_v) && guard < 200) begin
      if (a_i < n) begin
        ahbls_htrans = 2'b10;
        ahbls_haddr  = xq[a_i].addr;
        ahbls_hwrite = xq[a_i].write;
        ahbls_hsize  = xq[a_i].size;
        ahbls_hprot  = xq[a_i].addr[5:2];
      end else begin
        ahbls_htrans = 2'b00;
      end
      if (d_v) ahbls_hwdata = xq[d_i].wdata;
      @(negedge clk);
      if (d_v) begin
        dcyc++;
        if (ahbls_hresp) errc++;
      end
      if (ahbls_hready_resp) begin
        if (d_v && !xq[d_i].write && !ahbls_hresp)
          chk({tag, "_rdata"}, 64'(ahbls_hrdata), 64'(xq[d_i].rdata));
        if (a_i < n) begin
          d_i = a_i;
          d_v = 1'b1;
          a_i++;
        end else begin
          d_v = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      guard++;
    end
    ahbls_htrans = 2'b00;
    chk({tag, "_timeout"}, 64'(guard >= 200), 64'(0));
    xq.delete();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int dcyc;
    int errc;
    int first;
    int gap;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hready_resp", 64'(ahbls_hready_resp), 64'(1));
    chk("rst_hresp", 64'(ahbls_hresp), 64'(0));
    chk("rst_ahblm_htrans", 64'(ahblm_htrans), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Word write split into two halfwords, one stall cycle.
    add(32'h100, 1'b1, 3'd2, 32'hA5A5_1234, 32'h0);
    exp_q.push_back(mk(32'h100, 1'b1, 3'd1, 16'h1234));
    exp_q.push_back(mk(32'h102, 1'b1, 3'd1, 16'hA5A5));
    run("wwr", dcyc, errc);
    chk("wwr_dcycles", 64'(dcyc), 64'(2));
    chk_beats("wwr");

    // Word read assembles {high, low}.
    add(32'h200, 1'b0, 3'd2, 32'h0, 32'hCAFE_BEEF);
    exp_q.push_back(mk(32'h200, 1'b0, 3'd1, 16'h0));
    exp_q.push_back(mk(32'h202, 1'b0, 3'd1, 16'h0));
    run("wrd", dcyc, errc);
    chk("wrd_dcycles", 64'(dcyc), 64'(2));
    chk_beats("wrd");

    // Byte write in lane 3: single beat, upper downstream lane, no stall.
    add(32'h203, 1'b1, 3'd0, 32'h7700_0000, 32'h0);
    exp_q.push_back(mk(32'h203, 1'b1, 3'd0, 16'h7700));
    run("bwr", dcyc, errc);
    chk("bwr_dcycles", 64'(dcyc), 64'(1));
    chk_beats("bwr");

    // Back-to-back word, halfword, word reads: 5 beats in 5 consecutive cycles.
    first = obs_q.size();
    add(32'h300, 1'b0, 3'd2, 32'h0, {rd_fn(32'h302), rd_fn(32'h300)});
    add(32'h304, 1'b0, 3'd1, 32'h0, {rd_fn(32'h304), rd_fn(32'h304)});
    add(32'h308, 1'b0, 3'd2, 32'h0, {rd_fn(32'h30A), rd_fn(32'h308)});
    exp_q.push_back(mk(32'h300, 1'b0, 3'd1, 16'h0));
    exp_q.push_back(mk(32'h302, 1'b0, 3'd1, 16'h0));
    exp_q.push_back(mk(32'h304, 1'b0, 3'd1, 16'h0));
    exp_q.push_back(mk(32'h308, 1'b0, 3'd1, 16'h0));
    exp_q.push_back(mk(32'h30A, 1'b0, 3'd1, 16'h0));
    run("b2b", dcyc, errc);
    chk("b2b_dcycles", 64'(dcyc), 64'(5));
    gap = (cycq.size() >= first + 5) ? cycq[first+4] - cycq[first] : -1;
    chk("b2b_no_bubble", 64'(gap), 64'(4));
    chk_beats("b2b");

    // Error on the low half: no high-half beat, 2-cycle error upstream, next ok.
    cfg_err_addr = 32'h400;
    add(32'h400, 1'b0, 3'd2, 32'h0, 32'h0);
    add(32'h500, 1'b0, 3'd1, 32'h0, {rd_fn(32'h500), rd_fn(32'h500)});
    exp_q.push_back(mk(32'h400, 1'b0, 3'd1, 16'h0));
    exp_q.push_back(mk(32'h500, 1'b0, 3'd1, 16'h0));
    run("err", dcyc, errc);
    cfg_err_addr = 32'hFFFF_FFFF;
    chk("err_hresp_cycles", 64'(errc), 64'(2));
    chk("err_dcycles", 64'(dcyc), 64'(3));
    chk_beats("err");

    // One wait state per downstream beat stretches both halves.
    cfg_wait = 1;
    add(32'h600, 1'b1, 3'd2, 32'hDEAD_BEEF, 32'h0);
    exp_q.push_back(mk(32'h600, 1'b1, 3'd1, 16'hBEEF));
    exp_q.push_back(mk(32'h602, 1'b1, 3'd1, 16'hDEAD));
    run("wait", dcyc, errc);
    cfg_wait = 0;
    chk("wait_dcycles", 64'(dcyc), 64'(4));
    chk_beats("wait");

    // Reset while the high-half beat is being issued.
    ahbls_htrans = 2'b10;
    ahbls_haddr  = 32'h700;
    ahbls_hsize  = 3'd2;
    ahbls_hwrite = 1'b1;
    ahbls_hprot  = 4'h0;
    @(negedge clk);
    chk("rstmid_first_addr", 64'(ahblm_haddr), 64'(32'h700));
    @(posedge clk);
    #1;
    ahbls_htrans = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_second_htrans", 64'(ahblm_htrans), 64'(2'b10));
    chk("rstmid_second_addr", 64'(ahblm_haddr), 64'(32'h702));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_htrans", 64'(ahblm_htrans), 64'(2'b00));
    chk("rstmid_hready_resp", 64'(ahbls_hready_resp), 64'(1));
    chk("rstmid_hresp", 64'(ahbls_hresp), 64'(0));
    chk("rstmid_no_beats", 64'(obs_q.size() - obs_rd), 64'(0));
    @(posedge clk);
    #1;

    // Halfword write to the upper half after reset uses hwdata[31:16].
    add(32'h802, 1'b1, 3'd1, 32'h5555_0000, 32'h0);
    exp_q.push_back(mk(32'h802, 1'b1, 3'd1, 16'h5555));
    run("hwr", dcyc, errc);
    chk("hwr_dcycles", 64'(dcyc), 64'(1));
    chk_beats("hwr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
